// File: rtl/alu_seq.sv
// alu_seq: program sequencer that fetches 16-bit instructions and drives the alu control inputs.
// Define ALU_SEQ_CALL_EN for CALL/RET with a one-entry return register; the immediate port is alu_const (const is reserved).
module alu_seq #(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [2:0]      a_addr,
    output logic [2:0]      b_addr,
    output logic [7:0]      alu_const,
    output logic [2:0]      op,
    output logic            cin,
    output logic            alu_we,
    input  logic            zero,
    input  logic            neg,
    input  logic            cout,
    input  logic            ovf,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_EXEC, S_HALTED} state_t;

    localparam logic [1:0] CLS_REG = 2'b00;
    localparam logic [1:0] CLS_IMM = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_SYS = 2'b11;

    localparam logic [1:0] SYS_HALT = 2'b00;
    localparam logic [1:0] SYS_CALL = 2'b10;
    localparam logic [1:0] SYS_RET  = 2'b11;

    state_t          state_q;
    logic [PC_W-1:0] pc_q, imem_addr_q, tgt_q;
    logic [2:0]      a_q, b_q, op_q, fn_q;
    logic [7:0]      k_q;
    logic            cin_q, we_q, halted_q;
    logic [1:0]      cls_q;
    logic [3:0]      flags_q;   // {Z, N, C, V}
`ifdef ALU_SEQ_CALL_EN
    logic [PC_W-1:0] ret_pc_q;
`endif

    logic [PC_W-1:0] pc_inc, pc_d;
    logic            taken, is_halt;

    always_comb begin
        pc_inc  = pc_q + 1'b1;
        is_halt = (cls_q == CLS_SYS) && (fn_q[2:1] == SYS_HALT);
        case (fn_q)
            3'b001:  taken = flags_q[3];
            3'b010:  taken = !flags_q[3];
            3'b011:  taken = flags_q[2];
            3'b100:  taken = flags_q[1];
            3'b101:  taken = flags_q[0];
            3'b110:  taken = !flags_q[1];
            3'b111:  taken = !flags_q[2];
            default: taken = 1'b1;
        endcase
        pc_d = pc_inc;
        case (cls_q)
            CLS_BR: if (taken) pc_d = tgt_q;
            CLS_SYS: begin
                case (fn_q[2:1])
                    SYS_HALT: pc_d = pc_q;
`ifdef ALU_SEQ_CALL_EN
                    SYS_CALL: pc_d = tgt_q;
                    SYS_RET:  pc_d = ret_pc_q;
`endif
                    default:  pc_d = pc_inc;
                endcase
            end
            default: pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RST_PC;
            imem_addr_q <= RST_PC;
            tgt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            fn_q        <= '0;
            k_q         <= '0;
            cin_q       <= 1'b0;
            we_q        <= 1'b0;
            halted_q    <= 1'b0;
            cls_q       <= '0;
            flags_q     <= '0;
`ifdef ALU_SEQ_CALL_EN
            ret_pc_q    <= RST_PC;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        state_q     <= S_FETCH;
                        pc_q        <= RST_PC;
                        imem_addr_q <= RST_PC;
                        flags_q     <= '0;
                        halted_q    <= 1'b0;
                    end
                end
                S_FETCH: state_q <= S_ISSUE;
                S_ISSUE: begin
                    state_q <= S_EXEC;
                    cls_q   <= imem_data[15:14];
                    fn_q    <= imem_data[13:11];
                    tgt_q   <= imem_data[PC_W-1:0];
                    // Branch and SYS leave the alu controls untouched
                    case (imem_data[15:14])
                        CLS_REG: begin
                            op_q  <= imem_data[13:11];
                            a_q   <= imem_data[10:8];
                            b_q   <= imem_data[7:5];
                            k_q   <= '0;
                            cin_q <= imem_data[4] ? flags_q[1] : imem_data[3];
                            we_q  <= 1'b1;
                        end
                        CLS_IMM: begin
                            op_q  <= imem_data[13:11];
                            a_q   <= imem_data[10:8];
                            b_q   <= '0;
                            k_q   <= imem_data[7:0];
                            cin_q <= 1'b0;
                            we_q  <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_EXEC: begin
                    we_q        <= 1'b0;
                    pc_q        <= pc_d;
                    imem_addr_q <= pc_d;
                    if (!cls_q[1]) flags_q <= {zero, neg, cout, ovf};
`ifdef ALU_SEQ_CALL_EN
                    if (cls_q == CLS_SYS && fn_q[2:1] == SYS_CALL) ret_pc_q <= pc_inc;
`endif
                    if (is_halt) begin
                        state_q  <= S_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        state_q  <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign imem_addr = imem_addr_q;
    assign a_addr    = a_q;
    assign b_addr    = b_q;
    assign alu_const = k_q;
    assign op        = op_q;
    assign cin       = cin_q;
    assign alu_we    = we_q;
    assign pc        = pc_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: decode/branch vector table plus reset, Fibonacci, wrap/halt and call/return sequences.
`timescale 1ns/1ps
module tb_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, start2;
    logic        zero, neg, cout, ovf, fz2;
    logic [7:0]  imem_addr, pc;
    logic [15:0] imem_data, imem_data2;
    logic [2:0]  a_addr, b_addr, op;
    logic [7:0]  alu_const;
    logic        cin, alu_we, halted;
    logic [3:0]  imem_addr2, pc2;
    logic [2:0]  a2, b2, op2;
    logic [7:0]  k2;
    logic        cin2, we2, halted2;

    logic [15:0] mem  [256];
    logic [15:0] mem2 [16];

    always @(posedge clk) imem_data  <= mem[imem_addr];
    always @(posedge clk) imem_data2 <= mem2[imem_addr2];

    alu_seq #(.PC_W(8), .RST_PC(8'd0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
        .a_addr(a_addr), .b_addr(b_addr), .alu_const(alu_const), .op(op), .cin(cin), .alu_we(alu_we),
        .zero(zero), .neg(neg), .cout(cout), .ovf(ovf), .pc(pc), .halted(halted)
    );

    alu_seq #(.PC_W(4), .RST_PC(4'd3)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start2), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .a_addr(a2), .b_addr(b2), .alu_const(k2), .op(op2), .cin(cin2), .alu_we(we2),
        .zero(fz2), .neg(fz2), .cout(fz2), .ovf(fz2), .pc(pc2), .halted(halted2)
    );

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  fin;      // {zero, neg, cout, ovf} driven during EXEC
        logic [18:0] exp_out;  // {a, b, const, op, cin, we} during EXEC
        logic [7:0]  exp_pc;   // pc after EXEC
    } vec_t;

    vec_t tab [17];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] ins, input logic [3:0] fin,
                                input logic [2:0] a, input logic [2:0] b, input logic [7:0] k,
                                input logic [2:0] o, input logic c, input logic w, input logic [7:0] npc);
        vec_t v;
        v.instr   = ins;
        v.fin     = fin;
        v.exp_out = {a, b, k, o, c, w};
        v.exp_pc  = npc;
        return v;
    endfunction

    function automatic logic [18:0] outs();
        return {a_addr, b_addr, alu_const, op, cin, alu_we};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_instr();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0] addr;
        logic       we_seen, we_i;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; fz2 = 1'b0;
        {zero, neg, cout, ovf} = 4'b0000;
        for (int i = 0; i < 256; i++) mem[i] = 16'hD000;
        for (int i = 0; i < 16; i++) mem2[i] = 16'hD000;
        mem2[0] = 16'hC000;

        tab[0]  = mk(16'h2028, 4'b1000, 3'd0, 3'd1, 8'h00, 3'd4, 1'b1, 1'b1, 8'h01);
        tab[1]  = mk(16'h8810, 4'b0000, 3'd0, 3'd1, 8'h00, 3'd4, 1'b1, 1'b0, 8'h10);
        tab[2]  = mk(16'h9020, 4'b0000, 3'd0, 3'd1, 8'h00, 3'd4, 1'b1, 1'b0, 8'h11);
        tab[3]  = mk(16'h55A5, 4'b0110, 3'd5, 3'd0, 8'hA5, 3'd2, 1'b0, 1'b1, 8'h12);
        tab[4]  = mk(16'h0BD0, 4'b0001, 3'd3, 3'd6, 8'h00, 3'd1, 1'b1, 1'b1, 8'h13);
        tab[5]  = mk(16'h3FF8, 4'b0001, 3'd7, 3'd7, 8'h00, 3'd7, 1'b0, 1'b1, 8'h14);
        tab[6]  = mk(16'hA830, 4'b0000, 3'd7, 3'd7, 8'h00, 3'd7, 1'b0, 1'b0, 8'h30);
        tab[7]  = mk(16'hD000, 4'b0000, 3'd7, 3'd7, 8'h00, 3'd7, 1'b0, 1'b0, 8'h31);
        tab[8]  = mk(16'hA040, 4'b0000, 3'd7, 3'd7, 8'h00, 3'd7, 1'b0, 1'b0, 8'h32);
        tab[9]  = mk(16'h8803, 4'b0000, 3'd7, 3'd7, 8'h00, 3'd7, 1'b0, 1'b0, 8'h33);
        tab[10] = mk(16'hB050, 4'b0000, 3'd7, 3'd7, 8'h00, 3'd7, 1'b0, 1'b0, 8'h50);
        tab[11] = mk(16'h9860, 4'b0000, 3'd7, 3'd7, 8'h00, 3'd7, 1'b0, 1'b0, 8'h51);
        tab[12] = mk(16'hB870, 4'b0000, 3'd7, 3'd7, 8'h00, 3'd7, 1'b0, 1'b0, 8'h70);
        tab[13] = mk(16'h72FF, 4'b0010, 3'd2, 3'd0, 8'hFF, 3'd6, 1'b0, 1'b1, 8'h71);
        tab[14] = mk(16'h80FE, 4'b0000, 3'd2, 3'd0, 8'hFF, 3'd6, 1'b0, 1'b0, 8'hFE);
        tab[15] = mk(16'hD000, 4'b0000, 3'd2, 3'd0, 8'hFF, 3'd6, 1'b0, 1'b0, 8'hFF);
        tab[16] = mk(16'hC000, 4'b0000, 3'd2, 3'd0, 8'hFF, 3'd6, 1'b0, 1'b0, 8'hFF);
        addr = 8'h00;
        for (int i = 0; i < 17; i++) begin
            mem[addr] = tab[i].instr;
            addr      = tab[i].exp_pc;
        end

        // Reset: outputs at reset values and the sequencer stays idle without start
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        we_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            we_seen |= alu_we | we2;
        end
        check("rst_outs", {13'd0, outs()}, 32'd0);
        check("rst_pc_addr_halted", {pc, imem_addr, halted}, 32'd0);
        check("rst_no_we", {31'd0, we_seen}, 32'd0);
        check("rst_pc4_rstpc", {pc2, imem_addr2, halted2}, {23'd0, 4'd3, 4'd3, 1'b0});

        // Vector table: one instruction per record
        @(negedge clk);
        pulse_start();
        for (int i = 0; i < 17; i++) begin
            {zero, neg, cout, ovf} = tab[i].fin;
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_exec", i), {13'd0, outs()}, {13'd0, tab[i].exp_out});
            @(negedge clk);
            check($sformatf("vec%0d_pc", i), {24'd0, pc}, {24'd0, tab[i].exp_pc});
        end
        {zero, neg, cout, ovf} = 4'b0000;
        repeat (4) @(negedge clk);
        check("halt_hold", {pc, halted, alu_we}, {22'd0, 8'hFF, 1'b1, 1'b0});

        // Restart from HALTED clears the carry flag left set by the last ALU op
        mem[0] = 16'h2010;
        pulse_start();
        check("restart_pc", {pc, imem_addr, halted}, 32'd0);
        repeat (2) @(negedge clk);
        check("restart_flags_clr", {13'd0, outs()}, {13'd0, 3'd0, 3'd0, 8'h00, 3'd4, 1'b0, 1'b1});

        // Fibonacci loop
        @(negedge clk);
        do_reset();
        mem[0] = 16'h2100; mem[1] = 16'h2020; mem[2] = 16'h8000;
        @(negedge clk);
        pulse_start();
        for (int k = 0; k < 9; k++) begin
            check($sformatf("fib%0d_pc", k), {24'd0, pc}, k % 3);
            we_i = alu_we;
            @(negedge clk);
            we_i |= alu_we;
            @(negedge clk);
            check($sformatf("fib%0d_we_idle", k), {31'd0, we_i}, 32'd0);
            case (k % 3)
                0:       check($sformatf("fib%0d_exec", k), {a_addr, b_addr, op, alu_we}, {22'd0, 3'd1, 3'd0, 3'd4, 1'b1});
                1:       check($sformatf("fib%0d_exec", k), {a_addr, b_addr, op, alu_we}, {22'd0, 3'd0, 3'd1, 3'd4, 1'b1});
                default: check($sformatf("fib%0d_exec", k), {a_addr, b_addr, op, alu_we}, {22'd0, 3'd0, 3'd1, 3'd4, 1'b0});
            endcase
            @(negedge clk);
        end

        // Reset in the middle of an ALU EXEC
        repeat (2) @(negedge clk);
        check("midexec_we_before", {31'd0, alu_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1 check("midexec_we_drop", {13'd0, outs()}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        we_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            we_seen |= alu_we;
        end
        check("midexec_idle", {pc, imem_addr, halted, we_seen}, 32'd0);

        // Wrap and halt on the 4-bit instance, RST_PC = 3
        pulse_start2: begin
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
        end
        for (int i = 0; i < 13; i++) begin
            run_instr();
            check($sformatf("wrap_pc%0d", i), {28'd0, pc2}, (4 + i) % 16);
        end
        run_instr();
        check("wrap_halt", {pc2, halted2, we2}, {26'd0, 4'd0, 1'b1, 1'b0});
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("wrap_restart", {pc2, imem_addr2, halted2}, {23'd0, 4'd3, 4'd3, 1'b0});

        // Call / return
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = 16'hD000;
        mem[5] = 16'hE00A; mem[6] = 16'hC000; mem[10] = 16'hF000;
        @(negedge clk);
        pulse_start();
        repeat (5) run_instr();
        check("call_at5", {24'd0, pc}, 32'd5);
        we_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            we_seen |= alu_we;
        end
`ifdef ALU_SEQ_CALL_EN
        check("call_target", {24'd0, pc}, 32'd10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            we_seen |= alu_we;
        end
        check("ret_pc", {24'd0, pc}, 32'd6);
`else
        check("call_as_nop", {24'd0, pc}, 32'd6);
`endif
        check("call_no_we", {31'd0, we_seen}, 32'd0);
        run_instr();
        check("call_halt", {pc, halted}, {23'd0, 8'd6, 1'b1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
